// File: rtl/des3_cbc_dec_stream.sv
// des3_cbc_dec_stream
// Byte-stream wrapper around a 3DES decrypt core operating in CBC mode.
// Eight ciphertext bytes are packed MSB-first into a block, and the block is
// handed to the core with a one-cycle select pulse. The core result is XORed
// with the previous ciphertext block (or the IV), and the plaintext is
// streamed out MSB-first.
// Filling and draining never overlap: one block is in flight at a time.
module des3_cbc_dec_stream #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [63:0]      iv,
    input  logic             iv_load,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             core_select,
    output logic [63:0]      core_data_in,
    input  logic [63:0]      core_data_out,
    input  logic             core_done,
    output logic [CNT_W-1:0] block_cnt,
    output logic             err
);

    // The watchdog holds the number of WAIT cycles already spent. The select
    // cycle counts as the first cycle of the timeout window, so the block is
    // abandoned after TIMEOUT_CYCLES-1 WAIT cycles. This makes err rise
    // exactly TIMEOUT_CYCLES cycles after core_select.
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [63:0]       cblk_q, cblk_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       pblk_q, pblk_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // Plaintext byte lanes. Lane 0 is the most significant byte, and it is
    // the first byte sent out.
    logic [7:0] pblk_lane [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign pblk_lane[gi] = pblk_q[63-8*gi -: 8];
    end

    // Next-state and datapath update for the fill/start/wait/drain sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cblk_d  = cblk_q;
        chain_d = chain_q;
        pblk_d  = pblk_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_FILL: begin
                // An IV can only be taken at a block boundary. It may
                // coincide with the first byte of the block.
                if (iv_load && (idx_q == 3'd0)) begin
                    chain_d = iv;
                    err_d   = 1'b0;
                end
                if (in_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        if (idx_q == 3'(i)) begin
                            cblk_d[63-8*i -: 8] = in_data;
                        end
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_START;
                    end
                end
            end

            S_START: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (core_done) begin
                    pblk_d  = core_data_out ^ chain_q;
                    chain_d = cblk_q;
                    state_d = S_DRAIN;
                end else if (wdog_q == WD_LAST) begin
                    // Give up on this block and leave the chain untouched,
                    // so the next block still chains from the last good one.
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = S_FILL;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            S_DRAIN: begin
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_FILL;
                    end
                end
            end

            default: begin
                state_d = S_FILL;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            idx_q   <= 3'd0;
            cblk_q  <= '0;
            chain_q <= '0;
            pblk_q  <= '0;
            wdog_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cblk_q  <= cblk_d;
            chain_q <= chain_d;
            pblk_q  <= pblk_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Port outputs decoded from the registered state.
    always_comb begin
        in_ready     = (state_q == S_FILL);
        out_valid    = (state_q == S_DRAIN);
        out_data     = (state_q == S_DRAIN) ? pblk_lane[idx_q] : 8'h00;
        core_select  = (state_q == S_START);
        core_data_in = cblk_q;
        block_cnt    = cnt_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_des3_cbc_dec_stream.sv
// Testbench for des3_cbc_dec_stream. A stub 3DES core returns ct ^ all-ones.
// The expected plaintext comes from the plain CBC rule: P = D(C) ^ previous C.
module tb_des3_cbc_dec_stream;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int          CW   = 2;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [63:0] iv;
    logic        iv_load;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        core_select;
    logic [63:0] core_data_in;
    logic [63:0] core_data_out;
    logic        core_done;
    logic [CW-1:0] block_cnt;
    logic        err;

    always #5 clock = ~clock;

    des3_cbc_dec_stream #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
        .clock(clock), .rst_n(rst_n), .iv(iv), .iv_load(iv_load),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_select(core_select), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_done(core_done),
        .block_cnt(block_cnt), .err(err)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Stub core: answers core_delay cycles after the select cycle, unless it is
    // disabled. A forced done from the bench injects a stray pulse.
    bit          stub_en    = 1'b1;
    int          stub_delay = 5;
    int          stub_cnt   = 0;
    logic [63:0] stub_blk   = '0;
    int          done_cyc   = 0;
    bit          force_done = 1'b0;

    always @(negedge clock) begin
        core_done     = 1'b0;
        core_data_out = {$urandom, $urandom};
        if (!rst_n) begin
            stub_cnt = 0;
        end else if (force_done) begin
            core_done = 1'b1;
        end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
                core_done     = 1'b1;
                core_data_out = stub_blk ^ ONES;
                done_cyc      = cyc;
            end
        end else if (core_select && stub_en) begin
            stub_cnt = stub_delay;
            stub_blk = core_data_in;
        end
    end

    // Reference model state: the CBC chain value and the block count.
    logic [63:0] m_chain = '0;
    int          m_cnt   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"},  64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"},  64'(out_data), 64'd0);
        check({tag, "_core_sel"},  64'(core_select), 64'd0);
        check({tag, "_core_din"},  core_data_in, 64'd0);
        check({tag, "_block_cnt"}, 64'(block_cnt), 64'd0);
        check({tag, "_err"},       64'(err), 64'd0);
    endtask

    // Feed one ciphertext block, optionally with an IV on the first byte, and
    // optionally with a stray iv_load at byte index 4.
    task automatic send_block(input logic [63:0] ct, input bit do_iv, input logic [63:0] ivv,
                              input int gap_max, input bit iv_at4, input logic [63:0] iv4val,
                              output int sel_cyc);
        int  i = 0;
        int  n = 0;
        bit  iv4_done = 1'b0;
        sel_cyc = 0;
        while (i < 8) begin
            @(negedge clock);
            iv_load  = 1'b0;
            in_valid = 1'b0;
            n++;
            if (n > 300) begin
                tests++; fails++;
                $display("FAIL send_bound: got %0d bytes required 8", i);
                return;
            end
            if (iv_at4 && i == 4 && !iv4_done) begin
                iv_load  = 1'b1;
                iv       = iv4val;
                iv4_done = 1'b1;
                continue;
            end
            if (gap_max > 0 && $urandom_range(gap_max, 0) != 0) continue;
            if (!in_ready) continue;
            in_valid = 1'b1;
            in_data  = ct[63-8*i -: 8];
            if (do_iv && i == 0) begin
                iv_load = 1'b1;
                iv      = ivv;
            end
            i++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        iv_load  = 1'b0;
        check("core_select", 64'(core_select), 64'd1);
        check("core_data_in", core_data_in, ct);
        sel_cyc = cyc;
        @(negedge clock);
        check("select_pulse", 64'(core_select), 64'd0);
    endtask

    // Drain up to max_hs output bytes. Modes: 0 always ready, 1 ready in one
    // cycle of every three, 2 random ready.
    task automatic collect(input int mode, input int max_hs, output logic [63:0] got,
                           output int first_cyc);
        int   hs = 0;
        int   n = 0;
        bit   prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        bit   r;
        got = '0;
        first_cyc = -1;
        while (hs < max_hs && n < 300) begin
            @(negedge clock);
            n++;
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                check("in_ready_drain", 64'(in_ready), 64'd0);
                case (mode)
                    0:       r = 1'b1;
                    1:       r = (n % 3 == 0);
                    default: r = 1'($urandom_range(1, 0));
                endcase
                out_ready = r;
                if (r) begin
                    got[63-8*hs -: 8] = out_data;
                    hs++;
                end
                prev_stall = !r;
                prev_data  = out_data;
            end else begin
                out_ready  = 1'($urandom_range(1, 0));
                prev_stall = 1'b0;
            end
        end
        if (hs < max_hs) begin
            tests++; fails++;
            $display("FAIL drain_bound: got %0d handshakes required %0d", hs, max_hs);
        end
    endtask

    task automatic run_block(input logic [63:0] ct, input bit do_iv, input logic [63:0] ivv,
                             input int gap, input int mode, input int delay,
                             input bit iv_at4, input logic [63:0] iv4val,
                             output logic [63:0] got);
        logic [63:0] exp;
        int sel_c, first_c;
        stub_delay = delay;
        if (do_iv) m_chain = ivv;
        exp = (ct ^ ONES) ^ m_chain;
        send_block(ct, do_iv, ivv, gap, iv_at4, iv4val, sel_c);
        collect(mode, 8, got, first_c);
        m_chain = ct;
        m_cnt   = (m_cnt + 1) % (1 << CW);
        @(negedge clock);
        out_ready = 1'b0;
        check("plaintext", got, exp);
        check("first_out_latency", 64'(first_c), 64'(done_cyc + 1));
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
        check("block_cnt", 64'(block_cnt), 64'(m_cnt));
        $display("[TB] block ct=%h pt=%h exp=%h cnt=%0d", ct, got, exp, block_cnt);
    endtask

    typedef struct {
        logic [63:0] ct;
        bit          do_iv;
        logic [63:0] ivv;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [2];
    int   wrap_exp [5];

    initial begin
        logic [63:0] got;
        int sel_c, first_c, err_c;

        vecs[0] = '{64'h0102030405060708, 1'b1, 64'h0011223344556677, 64'hFEECDEC8BEAC9E80};
        vecs[1] = '{64'h1112131415161718, 1'b0, 64'h0, 64'hEFEFEFEFEFEFEFEF};
        wrap_exp = '{1, 2, 3, 0, 1};

        rst_n = 1'b0; iv = '0; iv_load = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outs("reset");
        rst_n = 1'b1;

        // Directed vectors: a single block, then a chained block.
        for (int k = 0; k < 2; k++) begin
            run_block(vecs[k].ct, vecs[k].do_iv, vecs[k].ivv, 0, 0, 5, 1'b0, '0, got);
            check("table_pt", got, vecs[k].exp);
        end

        // Backpressure: ready in one cycle of every three.
        run_block({$urandom, $urandom}, 1'b0, '0, 0, 1, 4, 1'b0, '0, got);

        // A stray iv_load at byte index 4 must leave the chain untouched.
        run_block({$urandom, $urandom}, 1'b0, '0, 0, 0, 3, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, got);

        // Timeout: the core never answers.
        stub_en = 1'b0;
        send_block({$urandom, $urandom}, 1'b0, '0, 0, 1'b0, '0, sel_c);
        err_c = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (out_valid) begin
                tests++; fails++;
                $display("FAIL timeout_out_valid: got 1 required 0");
            end
            if (err) begin
                err_c = cyc;
                break;
            end
        end
        check("timeout_cycle", 64'(err_c), 64'(sel_c + 16));
        check("timeout_in_ready", 64'(in_ready), 64'd1);
        check("timeout_block_cnt", 64'(block_cnt), 64'(m_cnt));
        $display("[TB] timeout err at cycle %0d (select %0d)", err_c, sel_c);
        stub_en = 1'b1;
        // The chain survives the timeout, and err stays set across a good block.
        run_block({$urandom, $urandom}, 1'b0, '0, 2, 2, 6, 1'b0, '0, got);
        check("err_sticky", 64'(err), 64'd1);
        // A lone iv_load at a block boundary clears err and reloads the chain.
        @(negedge clock);
        iv_load = 1'b1; iv = 64'h0F1E_2D3C_4B5A_6978;
        @(negedge clock);
        iv_load = 1'b0;
        m_chain = 64'h0F1E_2D3C_4B5A_6978;
        check("err_cleared", 64'(err), 64'd0);
        $display("[TB] iv_load after timeout err=%0d", err);
        run_block({$urandom, $urandom}, 1'b0, '0, 0, 0, 2, 1'b0, '0, got);

        // Reset during DRAIN after 3 output bytes; a late done is ignored.
        stub_delay = 3;
        send_block({$urandom, $urandom}, 1'b0, '0, 0, 1'b0, '0, sel_c);
        collect(0, 3, got, first_c);
        @(negedge clock);
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clock);
        check_reset_outs("mid_reset");
        rst_n = 1'b1;
        stub_en = 1'b0;
        force_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k == 1) force_done = 1'b0;
            check("late_done_valid", 64'(out_valid), 64'd0);
            check("late_done_ready", 64'(in_ready), 64'd1);
        end
        $display("[TB] reset during drain, late done ignored");
        stub_en = 1'b1;
        m_chain = '0;
        m_cnt   = 0;

        // Counter wrap: five blocks with a 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            run_block({$urandom, $urandom}, 1'b0, '0, 1, 0, 1 + k, 1'b0, '0, got);
            check("wrap_cnt", 64'(block_cnt), 64'(wrap_exp[k]));
        end

        // Randomized stream against the CBC reference model.
        for (int k = 0; k < 20; k++) begin
            bit do_iv;
            do_iv = ($urandom_range(3, 0) == 0);
            run_block({$urandom, $urandom}, do_iv, {$urandom, $urandom},
                      $urandom_range(2, 0), 2, $urandom_range(8, 1), 1'b0, '0, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
